// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch (IF)
// and the data memory stage (DM). Data accesses win arbitration unless a
// waiting fetch has already been passed over STARVE_LIMIT times in a row.
// Each access is a registered req/ack transaction of variable latency.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   if_req/if_addr/if_flush     fetch read request, address, branch flush
//   if_rdata/if_valid/if_stall  fetch data, completion pulse, stall
//   dm_req/dm_we/dm_addr/dm_wdata  data request, write enable, address, data
//   dm_rdata/dm_valid/dm_stall  data read data, completion pulse, stall
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ack           memory read data and completion
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  // Counter just wide enough to hold STARVE_LIMIT (1 bit when the bound is off).
  localparam int CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic BOUND_EN_C = (STARVE_LIMIT != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] starve_cnt_r;
  logic             discard_r;

  logic fetch_blocked_s;
  logic grant_dm_s;
  logic grant_if_s;
  logic ack_s;

  // Arbitration and completion decode.
  always_comb begin
    fetch_blocked_s = 1'b0;
    grant_dm_s      = 1'b0;
    grant_if_s      = 1'b0;
    ack_s           = mem_ack & mem_req;
    if_valid        = 1'b0;
    dm_valid        = 1'b0;

    // A fetch that has waited out the bound takes precedence over data.
    if (if_req && BOUND_EN_C && (starve_cnt_r == LIMIT_C)) begin
      fetch_blocked_s = 1'b1;
    end else begin
      fetch_blocked_s = 1'b0;
    end

    if (state_r == IDLE) begin
      grant_dm_s = dm_req & ~fetch_blocked_s;
      grant_if_s = ~grant_dm_s & if_req;
    end else begin
      grant_dm_s = 1'b0;
      grant_if_s = 1'b0;
    end

    // A flush arriving in the ack cycle itself also kills the pulse.
    if ((state_r == BUSY_IF) && ack_s && !discard_r && !if_flush) begin
      if_valid = 1'b1;
    end else begin
      if_valid = 1'b0;
    end

    if ((state_r == BUSY_DM) && ack_s) begin
      dm_valid = 1'b1;
    end else begin
      dm_valid = 1'b0;
    end
  end

  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;
  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

  // Access sequencer: grant, hold the memory request until ack, track starvation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      starve_cnt_r <= '0;
      discard_r    <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_dm_s) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            state_r   <= BUSY_DM;
            // Only data grants that actually overtake a waiting fetch count.
            if (if_req) begin
              if (starve_cnt_r != LIMIT_C) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1);
              end
            end else begin
              starve_cnt_r <= '0;
            end
          end else if (grant_if_s) begin
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= if_addr;
            mem_wdata    <= '0;
            state_r      <= BUSY_IF;
            starve_cnt_r <= '0;
          end
        end
        BUSY_IF: begin
          if (ack_s) begin
            mem_req   <= 1'b0;
            discard_r <= 1'b0;
            state_r   <= IDLE;
          end else if (if_flush) begin
            // The transaction must still complete; its data is just dropped.
            discard_r <= 1'b1;
          end
        end
        BUSY_DM: begin
          if (ack_s) begin
            mem_req <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          mem_req   <= 1'b0;
          discard_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Sits between the pipeline stages and the external memory.
- Arbitrates with data-side priority and a starvation bound for fetch.
- Generates per-stage stall signals and sequences each access through a req/ack handshake with variable memory latency.

Parameters:
- ADDR_W, 32, address width of both requester ports and the memory port.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending; 0 = strict data priority, no bound.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- if_req  in  1  fetch read request, level, held until if_valid.
- if_addr  in  ADDR_W  fetch address, stable while if_req high.
- if_flush  in  1  discard any in-flight fetch (branch taken).
- if_rdata  out  DATA_W  instruction data, valid only with if_valid.
- if_valid  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  fetch stage must hold.
- dm_req  in  1  data request, level, held until dm_valid.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_rdata  out  DATA_W  read data, valid only with dm_valid.
- dm_valid  out  1  one-cycle data completion pulse.
- dm_stall  out  1  memory stage (and all upstream) must hold.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack is high.
- mem_ack  in  1  memory completion, sampled only while mem_req is high.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset).
- Reset values:
  - mem_req, mem_we, mem_addr, mem_wdata = 0.
  - FSM = IDLE; starve_cnt = 0; discard = 0.
  - if_valid, dm_valid = 0.
  - Stalls follow their combinational equations.
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE arbitration, evaluated each cycle:
  - DM is granted if dm_req && !(if_req && STARVE_LIMIT != 0 && starve_cnt == STARVE_LIMIT).
  - Otherwise IF is granted if if_req.
  - Otherwise remain in IDLE.
- On a grant at edge N:
  - Register addr/we/wdata into mem_* (mem_we = 0 for IF).
  - Set mem_req = 1 and move to BUSY_IF or BUSY_DM.
  - mem_req is high from cycle N+1.
- BUSY_x:
  - mem_req and mem_* stay constant until mem_ack = 1.
  - In the ack cycle, x_valid = 1 combinationally and x_rdata = mem_rdata pass-through.
  - At the ack edge: mem_req returns to 0 and FSM returns to IDLE.
  - Minimum turnaround is 2 cycles per access (IDLE + ack cycle).
  - Latency to valid is 1 + memory wait cycles after the request is first seen in IDLE.
- The requester drops or changes its req at the edge where x_valid is sampled. IDLE therefore never re-issues a completed request.
- Writes: dm_valid pulses on ack; dm_rdata is don't-care.
- Stalls (combinational):
  - if_stall = if_req & ~if_valid.
  - dm_stall = dm_req & ~dm_valid.
- starve_cnt, saturating at STARVE_LIMIT:
  - DM grant with if_req high: increment.
  - DM grant with if_req low: clear.
  - IF grant: clear.
- Flush:
  - if_flush in BUSY_IF sets discard.
  - if_flush in the ack cycle itself also suppresses the pulse.
  - When discard is set, the ack completes the memory transaction with if_valid held at 0; discard clears and FSM goes to IDLE.
  - The new fetch address is then arbitrated normally.
  - if_flush in IDLE or BUSY_DM has no effect.
- mem_ack while mem_req = 0 is ignored.
- Simultaneous if_req and dm_req arriving in the ack cycle: arbitration happens in the following IDLE cycle.
- Reset mid-transaction: immediate return to reset values; the memory must tolerate an abandoned request.

Test Plan:
- IF read @0x40, memory acks in the first mem_req cycle with 0x2002_0005:
  - mem_req high exactly 1 cycle.
  - if_valid = 1 with if_rdata = 0x2002_0005 one cycle after if_req is seen.
  - if_stall = 1 for 1 cycle.
- if_req and dm_req (read @0x80) both held from the same cycle, 2-wait-state memory:
  - DM is served first, with mem_req high 3 cycles.
  - IF is served next.
  - dm_stall drops one transaction before if_stall.
- STARVE_LIMIT = 2, dm_req held continuously (dm_valid acknowledged, new addresses each time), if_req held: grant order is DM, DM, IF, DM, DM, IF.
- Fetch in BUSY_IF, if_flush pulsed, ack 3 cycles later:
  - No if_valid pulse.
  - Next mem_addr equals the new if_addr (0x100).
- dm_we = 1, addr 0x90, wdata 0xDEAD_BEEF:
  - mem_we = 1, mem_addr = 0x90, mem_wdata = 0xDEAD_BEEF for the whole transaction.
  - dm_valid pulses once on ack.
- reset asserted while in BUSY_DM:
  - mem_req = 0 asynchronously and FSM = IDLE.
  - A pending if_req is granted in the first cycle after deassert.
